data_bus_slave: RTL and testbench
=================================

# data_bus_slave

Responder for the CPU core's data-memory port: it sits on the other end of the `ram_ce_o / ram_we_o / ram_sel_o / ram_addr_o / ram_data_o / ram_data_i` bus.
- Decodes each access into a word-organised data RAM or a small memory-mapped I/O window.
- The MMIO window holds an LED register, a free-running cycle counter and a buffered 8N1 UART transmitter.
- Reads are combinational so the CPU's single-cycle MEM stage needs no stall. Writes commit on the clock edge.

## Interface
Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words (power of two).
- CLKS_PER_BIT, 868, clk cycles per UART bit (≥ 2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- ce  in  1  access enable (from CPU ram_ce_o).
- we  in  1  1 = write, 0 = read (from ram_we_o).
- addr  in  32  byte address (from ram_addr_o); addr[1:0] ignored.
- sel  in  4  byte-lane enables; sel[i] selects data bits [8i+7:8i].
- data_i  in  32  write data (from ram_data_o).
- data_o  out  32  read data (to ram_data_i).
- led  out  16  LED register.
- uart_tx  out  1  serial output, idle high.

## Operation
- Decode: addr[31:28]==4'h1 → MMIO. Otherwise → RAM word index addr[log2(RAM_WORDS)+1:2] (upper bits alias).
- RAM write: when ce&we, update only the lanes whose sel bit is set; other lanes are unchanged.
- RAM read: when ce&~we, data_o = full word. sel does not mask reads; the CPU extracts bytes.
- data_o = 0 when ce=0, when we=1, or on an unmapped MMIO offset.
- MMIO offsets (addr[3:0]):
  - 0x0 LED: RW. Write lanes 0/1 update led[7:0]/led[15:8]. Read returns {16'b0, led}.
  - 0x4 CYCLE: read returns the counter. Any write clears it.
  - 0x8 UART_DATA: write with sel[0]=1 pushes data_i[7:0] into the TX FIFO. Read returns 0.
  - 0xC UART_STATUS: read-only; {25'b0, count[2:0], 1'b0, empty, full, busy}.
- TX FIFO: depth 4, circular 2-bit pointers, 3-bit count.
  - A push while full is silently dropped. Fullness is judged before a same-cycle pop.
  - Push and pop in the same cycle when not full: count unchanged, both pointers advance.
- UART FSM states IDLE, START, DATA, STOP:
  - IDLE → START: FIFO non-empty. Pop the head into the shift register; uart_tx=0 from the next cycle.
  - START → DATA: after CLKS_PER_BIT cycles.
  - DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then → IDLE. A queued byte starts on the following cycle.
  - busy = (state != IDLE).

## Timing
- Reset values: led=0, uart_tx=1, counter=0, FIFO empty (count 0, pointers 0), FSM IDLE, data_o follows the combinational rule. RAM contents are not cleared.
- Read latency is 0 cycles (combinational from ce/we/addr).
- Write latency is 1 edge. A read of a location in the same cycle it is written returns the old value.
- CYCLE counter:
  - Increments every cycle and wraps 0xFFFFFFFF→0.
  - A write at edge N makes it read 0 in cycle N+1 and 1 in cycle N+2.
  - A read returns the pre-edge value.
- STATUS reflects state before the current edge. A push at edge N shows in count from cycle N+1.
- FIFO pop happens at the edge where IDLE→START; start bit drives from the cycle after that edge.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames insert one idle-high cycle between STOP and the next START.
- Reset mid-frame: uart_tx returns high the cycle after the reset edge, the FIFO is flushed and the frame is abandoned.

## Test plan
- RAM byte write: write 0xAABBCCDD to 0x00000010 sel=4'b1111, then 0x11223344 sel=4'b0101 → read 0x00000010 = 0xAA22CC44. Read with ce=0 → 0.
- Alias/same-cycle: write 0x12345678 to 0x00000000 → read at 0x00001000 (RAM_WORDS=1024) = 0x12345678. A read concurrent with the write returns the old value.
- LED/CYCLE: write 0xFFFF5A5A to 0x10000000 sel=4'b0001 → led=0x005A. Write 0x10000004 → reads 0,1,2 on following cycles. Preload-free wrap check: counter reaches 0xFFFFFFFF then 0.
- UART frame (CLKS_PER_BIT=4): push 0x55 → uart_tx sequence 0,1,0,1,0,1,0,1,0,1 each held 4 cycles. busy=1 for 40 cycles, then STATUS=0x4.
- FIFO full: push 6 bytes 0x01..0x06 in consecutive cycles while idle → first pops at once, FIFO then holds 0x02–0x05, full=1, 0x06 dropped. Frames emitted 0x01..0x05 only.
- Reset mid-frame: assert rst during DATA bit 3 → uart_tx=1, STATUS=0x4, led=0, CYCLE=0 after release. A RAM word written before reset still reads back unchanged.

Source files
------------

// File: rtl/data_bus_slave.sv
// Data-memory bus responder: word RAM plus MMIO window
// holding LEDs, a cycle counter and a buffered 8N1 UART.
module data_bus_slave #(
    parameter int RAM_WORDS    = 1024,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [15:0] led,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    logic [31:0]   mem [RAM_WORDS];
    logic          is_mmio;
    logic [AW-1:0] word_idx;
    logic [1:0]    reg_off;
    logic          wr_acc;
    logic          rd_acc;
    logic          ram_wr;
    logic          led_wr;
    logic          cyc_wr;
    logic          push;
    logic          unused_addr;

    assign is_mmio     = (addr[31:28] == 4'h1);
    assign word_idx    = addr[AW+1:2];
    assign reg_off     = addr[3:2];
    assign wr_acc      = ce & we;
    assign rd_acc      = ce & ~we;
    assign ram_wr      = wr_acc & ~is_mmio;
    assign led_wr      = wr_acc & is_mmio & (reg_off == 2'd0);
    assign cyc_wr      = wr_acc & is_mmio & (reg_off == 2'd1);
    assign push        = wr_acc & is_mmio & (reg_off == 2'd2) & sel[0];
    assign unused_addr = ^addr;

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    mem[word_idx][8*i +: 8] <= data_i[8*i +: 8];
                end
            end
        end
    end

    logic [31:0] cycle;

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else if (led_wr) begin
            if (sel[0]) led[7:0]  <= data_i[7:0];
            if (sel[1]) led[15:8] <= data_i[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cyc_wr) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_ok;
    logic       pop;

    assign fifo_full  = (fifo_cnt == 3'd4);
    assign fifo_empty = (fifo_cnt == 3'd0);
    // Fullness is judged before any same-cycle pop.
    assign push_ok    = push & ~fifo_full;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + 3'(push_ok) - 3'(pop);
        end
    end

    uart_state_t   state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          bit_done;
    logic          busy;

    assign bit_done = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            uart_tx <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        tx_n      = uart_tx;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_n   = fifo_mem[rd_ptr];
                    clk_cnt_n = '0;
                    tx_n      = 1'b0;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    tx_n      = shreg[0];
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_cnt_n = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (bit_done) begin
                    clk_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic [31:0] status;

    assign status = {25'b0, fifo_cnt, 1'b0,
                     fifo_empty, fifo_full, busy};

    always_comb begin
        data_o = '0;
        if (rd_acc) begin
            if (is_mmio) begin
                unique case (reg_off)
                    2'd0:    data_o = {16'b0, led};
                    2'd1:    data_o = cycle;
                    2'd3:    data_o = status;
                    default: data_o = '0;
                endcase
            end else begin
                data_o = mem[word_idx];
            end
        end
    end

endmodule

// File: tb/tb_data_bus_slave.sv
// Randomised self-checking bench for data_bus_slave
// against a queue/array reference model.
module tb_data_bus_slave;

    localparam int CPB = 4;
    localparam logic [31:0] A_LED  = 32'h1000_0000;
    localparam logic [31:0] A_CYC  = 32'h1000_0004;
    localparam logic [31:0] A_UART = 32'h1000_0008;
    localparam logic [31:0] A_STAT = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic [15:0] led;
    logic        uart_tx;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rx_q [$];

    data_bus_slave #(
        .RAM_WORDS(1024),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .we(we),
        .addr(addr),
        .sel(sel),
        .data_i(data_i),
        .data_o(data_o),
        .led(led),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Serial receiver: samples each bit at its midpoint.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (CPB / 2) @(posedge clk);
            #1;
            if (uart_tx === 1'b0) begin
                b = '0;
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    b[j] = uart_tx;
                end
                rx_q.push_back(b);
                repeat (CPB) @(posedge clk);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a,
                      input logic [3:0] s,
                      input logic [31:0] d);
        ce = 1'b1; we = 1'b1;
        addr = a; sel = s; data_i = d;
        tick();
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a,
                      output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        d = data_o;
        ce = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rd(A_CYC, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_err++;
            $display("FAIL rst_cycle: got %h expected 0", v);
        end
        n_cmp++;
        if (led !== 16'h0) begin
            n_err++;
            $display("FAIL rst_led: got %h expected 0", led);
        end
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL rst_tx: got %b expected 1", uart_tx);
        end
        rd(A_STAT, v);
        n_cmp++;
        if (v !== 32'h4) begin
            n_err++;
            $display("FAIL rst_status: got %h expected 4", v);
        end
        addr = A_LED; ce = 1'b0;
        #1;
        n_cmp++;
        if (data_o !== 32'h0) begin
            n_err++;
            $display("FAIL rst_ce0: got %h expected 0", data_o);
        end
    endtask

    task automatic test_ram_bytes();
        logic [31:0] v;
        wr(32'h10, 4'b1111, 32'hAABBCCDD);
        wr(32'h10, 4'b0101, 32'h11223344);
        rd(32'h10, v);
        n_cmp++;
        if (v !== 32'hAA22CC44) begin
            n_err++;
            $display("FAIL ram_bytes: got %h expected aa22cc44", v);
        end
        ce = 1'b0; addr = 32'h10;
        #1;
        n_cmp++;
        if (data_o !== 32'h0) begin
            n_err++;
            $display("FAIL ram_ce0: got %h expected 0", data_o);
        end
    endtask

    task automatic test_alias_same_cycle();
        logic [31:0] v;
        wr(32'h0, 4'hF, 32'hCAFEF00D);
        rd(32'h0, v);
        n_cmp++;
        if (v !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL old_val: got %h expected cafef00d", v);
        end
        ce = 1'b1; we = 1'b1; addr = 32'h0;
        sel = 4'hF; data_i = 32'h12345678;
        #1;
        n_cmp++;
        if (data_o !== 32'h0) begin
            n_err++;
            $display("FAIL wr_data_o: got %h expected 0", data_o);
        end
        tick();
        ce = 1'b0; we = 1'b0;
        rd(32'h1000, v);
        n_cmp++;
        if (v !== 32'h12345678) begin
            n_err++;
            $display("FAIL alias: got %h expected 12345678", v);
        end
    endtask

    task automatic test_ram_random();
        logic [31:0] ref_mem [1024];
        int          wq [$];
        logic [31:0] a, d, v;
        logic [3:0]  s;
        int          idx;
        for (int k = 0; k < 40; k++) begin
            idx = $urandom_range(0, 1023);
            d = $urandom;
            s = 4'($urandom);
            if (!(idx inside {wq})) begin
                s = 4'hF;
                wq.push_back(idx);
            end
            for (int i = 0; i < 4; i++) begin
                if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
            end
            a = $urandom;
            if (a[31:28] == 4'h1) a[31:28] = 4'h0;
            a[11:2] = 10'(idx);
            wr(a, s, d);
        end
        for (int k = 0; k < 30; k++) begin
            idx = wq[$urandom_range(0, wq.size() - 1)];
            a = $urandom;
            if (a[31:28] == 4'h1) a[31:28] = 4'h3;
            a[11:2] = 10'(idx);
            rd(a, v);
            n_cmp++;
            if (v !== ref_mem[idx]) begin
                n_err++;
                $display("FAIL ram_rand[%0d]: got %h expected %h",
                         idx, v, ref_mem[idx]);
            end
            tick();
        end
    endtask

    task automatic test_led_cycle();
        logic [31:0] v, d;
        logic [3:0]  s;
        logic [15:0] m;
        wr(A_LED, 4'b0001, 32'hFFFF5A5A);
        m = 16'h005A;
        n_cmp++;
        if (led !== m) begin
            n_err++;
            $display("FAIL led_dir: got %h expected %h", led, m);
        end
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            s = 4'($urandom);
            if (s[0]) m[7:0] = d[7:0];
            if (s[1]) m[15:8] = d[15:8];
            wr(A_LED, s, d);
            rd(A_LED, v);
            n_cmp++;
            if (v !== {16'h0, m} || led !== m) begin
                n_err++;
                $display("FAIL led_rand: got %h/%h expected %h",
                         v, led, m);
            end
        end
        wr(A_CYC, 4'($urandom), $urandom);
        for (int k = 0; k < 3; k++) begin
            rd(A_CYC, v);
            n_cmp++;
            if (v !== 32'(k)) begin
                n_err++;
                $display("FAIL cycle_%0d: got %h expected %h",
                         k, v, 32'(k));
            end
            tick();
        end
    endtask

    task automatic test_uart_frame();
        logic [9:0]  frame;
        logic [31:0] v;
        logic        eb;
        frame = {1'b1, 8'h55, 1'b0};
        rx_q.delete();
        wr(A_UART, 4'b0001, 32'hABCD_EF55);
        rd(A_STAT, v);
        n_cmp++;
        if (v !== 32'h10) begin
            n_err++;
            $display("FAIL uart_queued: got %h expected 10", v);
        end
        for (int i = 0; i < 10 * CPB; i++) begin
            tick();
            eb = frame[i / CPB];
            n_cmp++;
            if (uart_tx !== eb) begin
                n_err++;
                $display("FAIL uart_bit@%0d: got %b expected %b",
                         i, uart_tx, eb);
            end
            rd(A_STAT, v);
            n_cmp++;
            if (v !== 32'h5) begin
                n_err++;
                $display("FAIL uart_busy@%0d: got %h expected 5",
                         i, v);
            end
        end
        tick();
        rd(A_STAT, v);
        n_cmp++;
        if (v !== 32'h4 || uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL uart_done: got %h/%b expected 4/1",
                     v, uart_tx);
        end
        n_cmp++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
            n_err++;
            $display("FAIL uart_rx: got %0d bytes expected 1 (55)",
                     rx_q.size());
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0]  fifo_m [$];
        logic [7:0]  exp_q [$];
        logic [31:0] v, es;
        bit          idle, full;
        int          k;
        idle = 1'b1;
        for (int p = 1; p <= 6; p++) begin
            full = (fifo_m.size() == 4);
            if (idle && fifo_m.size() > 0) begin
                exp_q.push_back(fifo_m.pop_front());
                idle = 1'b0;
            end
            if (!full) fifo_m.push_back(8'(p));
        end
        es = 32'(fifo_m.size()) << 4;
        if (fifo_m.size() == 4) es = es | 32'h2;
        if (fifo_m.size() == 0) es = es | 32'h4;
        if (!idle) es = es | 32'h1;
        while (fifo_m.size() > 0) exp_q.push_back(fifo_m.pop_front());
        rx_q.delete();
        for (int p = 1; p <= 6; p++) begin
            wr(A_UART, 4'b0001, 32'(p));
        end
        rd(A_STAT, v);
        n_cmp++;
        if (v !== es) begin
            n_err++;
            $display("FAIL fifo_status: got %h expected %h", v, es);
        end
        k = 0;
        v = 32'h0;
        while (k < 400 && !(rx_q.size() >= 5 && v == 32'h4)) begin
            tick();
            rd(A_STAT, v);
            k++;
        end
        n_cmp++;
        if (k >= 400) begin
            n_err++;
            $display("FAIL fifo_drain: got timeout expected idle");
        end
        repeat (60) tick();
        n_cmp++;
        if (rx_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL fifo_frames: got %0d expected %0d",
                     rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (rx_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL fifo_byte%0d: got %h expected %h",
                             i, rx_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v, keep;
        keep = $urandom;
        wr(32'h40, 4'hF, keep);
        wr(A_LED, 4'b0011, 32'h0000A5A5);
        wr(A_UART, 4'b0001, 32'h3C);
        repeat (18) tick();
        rd(A_STAT, v);
        n_cmp++;
        if (uart_tx !== 1'b1 || v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_bit3: got %b/%h expected 1/busy",
                     uart_tx, v);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (uart_tx !== 1'b1 || led !== 16'h0) begin
            n_err++;
            $display("FAIL mid_rst: got %b/%h expected 1/0000",
                     uart_tx, led);
        end
        rd(A_CYC, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL mid_cycle: got %h expected 0", v);
        end
        rd(A_STAT, v);
        n_cmp++;
        if (v !== 32'h4) begin
            n_err++;
            $display("FAIL mid_status: got %h expected 4", v);
        end
        repeat (10) tick();
        rd(32'h40, v);
        n_cmp++;
        if (v !== keep || uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL mid_ram: got %h/%b expected %h/1",
                     v, uart_tx, keep);
        end
    endtask

    initial begin
        test_reset();
        test_ram_bytes();
        test_alias_same_cycle();
        test_ram_random();
        test_led_cycle();
        test_uart_frame();
        test_fifo_full();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
